screen_flow_ctrl: RTL and testbench
===================================

# screen_flow_ctrl

Game-flow controller and final pixel selector that sits directly downstream of the welcome-screen renderer. It owns the screen state machine: welcome, game, then game-over, then back to welcome. It consumes the 8-bit pixel streams from the welcome, game and game-over screen renderers and emits one registered RGB stream to the VGA output stage. All screen changes happen on frame boundaries so that no frame ever mixes two screens.

## Interface
Parameters:
- GAMEOVER_HOLD_FRAMES, 120: number of frames the game-over screen is shown before a start key is accepted.

Ports:
- clk  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse, once per frame, at the first pixel.
- keyStart  in  1  debounced start-key level; 1 = pressed.
- gameOver  in  1  from game logic; sampled as a level or a pulse.
- RGB_screen_welcome  in  8  welcome-screen pixel for the current pixelX/pixelY.
- RGB_screen_game  in  8  game-screen pixel.
- RGB_screen_gameover  in  8  game-over-screen pixel.
- RGB_out  out  8  selected pixel, registered.
- screenState  out  2  current state: 0 = WELCOME, 1 = GAME, 2 = GAME_OVER.
- gameEnable  out  1  high while screenState is GAME.
- newGame  out  1  one-cycle pulse on entry to GAME; the game logic uses it to reset score and ball.

## Operation
- Key edge detection:
  - keyPrev register. keyEdge = keyStart & ~keyPrev.
  - keyPrev resets to 1, so a key held through reset does not produce an edge.
- Pending requests:
  - reqStart is set by keyEdge in WELCOME. It is also set by keyEdge in GAME_OVER, but only when holdDone = 1.
  - reqOver is set while gameOver = 1 in GAME.
  - Both clear when the state changes.
  - Key edges in GAME are ignored. gameOver outside GAME is ignored.
- State transitions take effect only on a cycle with startOfFrame = 1:
  - WELCOME → GAME when reqStart, or keyEdge in the same cycle.
  - GAME → GAME_OVER when reqOver, or gameOver in the same cycle.
  - GAME_OVER → WELCOME when reqStart, or a qualified keyEdge in the same cycle.
  - Code 3 is illegal: go to WELCOME on the next clock, with RGB_out = 8'h00.
- Hold counter:
  - Width $clog2(GAMEOVER_HOLD_FRAMES+1).
  - Cleared on entry to GAME_OVER.
  - Increments on each startOfFrame while in GAME_OVER, saturating at GAMEOVER_HOLD_FRAMES.
  - holdDone = (count == GAMEOVER_HOLD_FRAMES).
- Pixel mux: RGB_out <= the input selected by screenState (WELCOME → welcome, GAME → game, GAME_OVER → gameover, 3 → 8'h00).

## Timing
- Reset values: screenState = WELCOME, RGB_out = 8'h00, gameEnable = 0, newGame = 0, count = 0, reqStart = reqOver = 0, keyPrev = 1.
- Reset mid-game or mid-hold returns to WELCOME on the next clock. Pending requests are discarded.
- RGB_out latency: 1 clock. RGB_out(t+1) = mux(screenState(t), inputs(t)).
- Request to switch:
  - A request raised in frame N switches at the startOfFrame edge that begins frame N+1.
  - The new screenState is visible the cycle after that edge.
  - The first pixel of the new screen appears on RGB_out one cycle later.
- A request that coincides with a startOfFrame cycle switches on that same edge.
- newGame asserts in the first cycle screenState = GAME, and for that cycle only.
- gameEnable is combinational from screenState, so it is cycle-aligned with screenState.
- Multiple key edges within one frame produce a single transition.

## Test plan
- Reset, then drive inputs welcome = 8'h1C, game = 8'hE0, gameover = 8'h03. Expect RGB_out = 8'h00 during reset, then 8'h1C from the second cycle after reset is released.
- Hold keyStart high through reset and release reset. Expect no transition across 3 frames. Then release the key and press it mid-frame. Expect screenState = 1 after the next startOfFrame, a 1-cycle newGame pulse, and RGB_out = 8'hE0 one cycle later.
- In GAME, pulse gameOver for 1 cycle mid-frame and press the key in the same frame. Expect GAME_OVER at the next frame start and RGB_out = 8'h03.
- With GAMEOVER_HOLD_FRAMES = 4: press the key during frames 1–3 of GAME_OVER. Expect it ignored. Press after the 4th startOfFrame. Expect WELCOME at the following frame start.
- Assert reset mid-GAME. Expect screenState = 0, gameEnable = 0 and RGB_out = 8'h00 the next cycle.
- Raise gameOver and startOfFrame in the same cycle. Expect GAME_OVER on that same clock edge.

Source files
------------

// File: rtl/screen_flow_ctrl.sv
// Screen flow FSM (welcome/game/game-over) and registered pixel selector.
// Ports: clk, reset, startOfFrame, keyStart, gameOver, three 8-bit screen
// pixels in; RGB_out, screenState, gameEnable, newGame out.
module screen_flow_ctrl #(
  parameter int GAMEOVER_HOLD_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       keyStart,
  input  logic       gameOver,
  input  logic [7:0] RGB_screen_welcome,
  input  logic [7:0] RGB_screen_game,
  input  logic [7:0] RGB_screen_gameover,
  output logic [7:0] RGB_out,
  output logic [1:0] screenState,
  output logic       gameEnable,
  output logic       newGame
);

  localparam int CW = $clog2(GAMEOVER_HOLD_FRAMES + 1);
  localparam logic [CW-1:0] HOLD = CW'(GAMEOVER_HOLD_FRAMES);

  localparam logic [1:0] S_WELCOME = 2'd0;
  localparam logic [1:0] S_GAME    = 2'd1;
  localparam logic [1:0] S_OVER    = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [7:0]    rgb_q, rgb_d;
  logic          new_q, new_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_start_q, req_start_d;
  logic          req_over_q, req_over_d;
  logic          key_prev_q;

  logic key_edge;
  logic hold_done;

  assign key_edge  = keyStart & ~key_prev_q;
  assign hold_done = (cnt_q == HOLD);

  always_comb begin
    state_d     = state_q;
    req_start_d = req_start_q;
    req_over_d  = req_over_q;
    cnt_d       = cnt_q;
    rgb_d       = 8'h00;
    case (state_q)
      S_WELCOME: begin
        rgb_d = RGB_screen_welcome;
        if (key_edge)
          req_start_d = 1'b1;
        if (startOfFrame && (req_start_q || key_edge))
          state_d = S_GAME;
      end
      S_GAME: begin
        rgb_d = RGB_screen_game;
        if (gameOver)
          req_over_d = 1'b1;
        if (startOfFrame && (req_over_q || gameOver))
          state_d = S_OVER;
      end
      S_OVER: begin
        rgb_d = RGB_screen_gameover;
        if (key_edge && hold_done)
          req_start_d = 1'b1;
        if (startOfFrame && !hold_done)
          cnt_d = cnt_q + 1'b1;
        if (startOfFrame &&
            (req_start_q || (key_edge && hold_done)))
          state_d = S_WELCOME;
      end
      default: begin
        // Illegal code: recover to welcome, black pixel.
        rgb_d   = 8'h00;
        state_d = S_WELCOME;
      end
    endcase
    // Requests belong to the screen that raised them.
    if (state_d != state_q) begin
      req_start_d = 1'b0;
      req_over_d  = 1'b0;
    end
    if (state_d == S_OVER && state_q != S_OVER)
      cnt_d = '0;
    new_d = (state_d == S_GAME) && (state_q != S_GAME);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_WELCOME;
      rgb_q       <= 8'h00;
      new_q       <= 1'b0;
      cnt_q       <= '0;
      req_start_q <= 1'b0;
      req_over_q  <= 1'b0;
      // Held key across reset must not look like a press.
      key_prev_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      rgb_q       <= rgb_d;
      new_q       <= new_d;
      cnt_q       <= cnt_d;
      req_start_q <= req_start_d;
      req_over_q  <= req_over_d;
      key_prev_q  <= keyStart;
    end
  end

  assign RGB_out     = rgb_q;
  assign screenState = state_q;
  assign gameEnable  = (state_q == S_GAME);
  assign newGame     = new_q;

endmodule

// File: tb/tb_screen_flow_ctrl.sv
// Bench for screen_flow_ctrl: RGB scoreboard plus
// per-scenario inline checks of state and pulses.
module tb_screen_flow_ctrl;

  localparam int HOLD = 4;
  localparam int F    = 8;

  logic       clk;
  logic       reset;
  logic       startOfFrame;
  logic       keyStart;
  logic       gameOver;
  logic [7:0] pw, pg, po;
  logic [7:0] RGB_out;
  logic [1:0] screenState;
  logic       gameEnable;
  logic       newGame;

  screen_flow_ctrl #(.GAMEOVER_HOLD_FRAMES(HOLD)) dut (
    .clk                (clk),
    .reset              (reset),
    .startOfFrame       (startOfFrame),
    .keyStart           (keyStart),
    .gameOver           (gameOver),
    .RGB_screen_welcome (pw),
    .RGB_screen_game    (pg),
    .RGB_screen_gameover(po),
    .RGB_out            (RGB_out),
    .screenState        (screenState),
    .gameEnable         (gameEnable),
    .newGame            (newGame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] sb[$];
  logic [1:0] exp_st;
  int         vectors;
  int         miscompares;
  bit         rnd;

  function automatic logic [7:0] ref_pix(input logic [1:0] s);
    case (s)
      2'd0:    return pw;
      2'd1:    return pg;
      2'd2:    return po;
      default: return 8'h00;
    endcase
  endfunction

  // One clock: push expected pixel, advance, update model state.
  task automatic tick(input logic sof, input logic [1:0] nxt);
    startOfFrame = sof;
    if (rnd) begin
      pw = 8'($urandom);
      pg = 8'($urandom);
      po = 8'($urandom);
    end
    sb.push_back(reset ? 8'h00 : ref_pix(exp_st));
    @(posedge clk);
    #1;
    exp_st = reset ? 2'd0 : nxt;
    startOfFrame = 1'b0;
  endtask

  task automatic idle(input int n, input logic [1:0] st);
    repeat (n) tick(1'b0, st);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [7:0] e;
      e = sb.pop_front();
      vectors++;
      if (RGB_out !== e) begin
        miscompares++;
        $display("FAIL rgb_out got %h want %h t=%0t",
                 RGB_out, e, $time);
      end
      vectors++;
      if (screenState !== exp_st ||
          gameEnable !== (exp_st == 2'd1)) begin
        miscompares++;
        $display("FAIL state got %0d/en%b want %0d t=%0t",
                 screenState, gameEnable, exp_st, $time);
      end
    end
  end

  task automatic test_reset;
    reset = 1'b1;
    keyStart = 1'b0;
    gameOver = 1'b0;
    pw = 8'h1C;
    pg = 8'hE0;
    po = 8'h03;
    repeat (3) tick(1'b0, 2'd0);
    vectors++;
    if ({screenState, gameEnable, newGame, RGB_out} !==
        {2'd0, 1'b0, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_vals got %0d %b %b %h want 0 0 0 00",
               screenState, gameEnable, newGame, RGB_out);
    end
    reset = 1'b0;
    tick(1'b0, 2'd0);
    vectors++;
    if (RGB_out !== 8'h1C) begin
      miscompares++;
      $display("FAIL post_reset_rgb got %h want 1c", RGB_out);
    end
    idle(2, 2'd0);
  endtask

  task automatic test_key_through_reset;
    reset = 1'b1;
    keyStart = 1'b1;
    tick(1'b0, 2'd0);
    tick(1'b0, 2'd0);
    reset = 1'b0;
    repeat (3) begin
      tick(1'b1, 2'd0);
      idle(F - 1, 2'd0);
    end
    vectors++;
    if (screenState !== 2'd0) begin
      miscompares++;
      $display("FAIL held_key got %0d want 0", screenState);
    end
    keyStart = 1'b0;
    tick(1'b0, 2'd0);
    keyStart = 1'b1;
    tick(1'b0, 2'd0);
    keyStart = 1'b0;
    idle(3, 2'd0);
    tick(1'b1, 2'd1);
    vectors++;
    if ({screenState, gameEnable, newGame} !== {2'd1, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL enter_game got %0d %b %b want 1 1 1",
               screenState, gameEnable, newGame);
    end
    tick(1'b0, 2'd1);
    vectors++;
    if (newGame !== 1'b0 || RGB_out !== 8'hE0) begin
      miscompares++;
      $display("FAIL newgame_pulse got %b %h want 0 e0",
               newGame, RGB_out);
    end
  endtask

  task automatic test_gameover_key;
    idle(2, 2'd1);
    gameOver = 1'b1;
    tick(1'b0, 2'd1);
    gameOver = 1'b0;
    idle(1, 2'd1);
    keyStart = 1'b1;
    tick(1'b0, 2'd1);
    keyStart = 1'b0;
    idle(2, 2'd1);
    tick(1'b1, 2'd2);
    vectors++;
    if (screenState !== 2'd2 || gameEnable !== 1'b0) begin
      miscompares++;
      $display("FAIL enter_over got %0d %b want 2 0",
               screenState, gameEnable);
    end
    tick(1'b0, 2'd2);
    vectors++;
    if (RGB_out !== 8'h03) begin
      miscompares++;
      $display("FAIL over_rgb got %h want 03", RGB_out);
    end
  endtask

  task automatic test_hold;
    for (int i = 0; i < HOLD; i++) begin
      idle(2, 2'd2);
      keyStart = 1'b1;
      tick(1'b0, 2'd2);
      keyStart = 1'b0;
      idle(2, 2'd2);
      tick(1'b1, 2'd2);
      vectors++;
      if (screenState !== 2'd2) begin
        miscompares++;
        $display("FAIL hold_ignore[%0d] got %0d want 2",
                 i, screenState);
      end
    end
    idle(1, 2'd2);
    keyStart = 1'b1;
    tick(1'b0, 2'd2);
    keyStart = 1'b0;
    idle(2, 2'd2);
    tick(1'b1, 2'd0);
    vectors++;
    if (screenState !== 2'd0) begin
      miscompares++;
      $display("FAIL hold_release got %0d want 0", screenState);
    end
    tick(1'b0, 2'd0);
  endtask

  task automatic test_reset_mid_game;
    keyStart = 1'b1;
    tick(1'b0, 2'd0);
    keyStart = 1'b0;
    tick(1'b1, 2'd1);
    idle(3, 2'd1);
    reset = 1'b1;
    tick(1'b0, 2'd0);
    vectors++;
    if ({screenState, gameEnable, RGB_out} !== {2'd0, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_mid got %0d %b %h want 0 0 00",
               screenState, gameEnable, RGB_out);
    end
    reset = 1'b0;
    tick(1'b0, 2'd0);
    keyStart = 1'b1;
    tick(1'b0, 2'd0);
    keyStart = 1'b0;
    reset = 1'b1;
    tick(1'b0, 2'd0);
    reset = 1'b0;
    tick(1'b1, 2'd0);
    vectors++;
    if (screenState !== 2'd0) begin
      miscompares++;
      $display("FAIL req_discard got %0d want 0", screenState);
    end
  endtask

  task automatic test_same_cycle;
    keyStart = 1'b1;
    tick(1'b0, 2'd0);
    keyStart = 1'b0;
    tick(1'b1, 2'd1);
    idle(3, 2'd1);
    gameOver = 1'b1;
    tick(1'b1, 2'd2);
    gameOver = 1'b0;
    vectors++;
    if (screenState !== 2'd2) begin
      miscompares++;
      $display("FAIL over_same_sof got %0d want 2", screenState);
    end
    tick(1'b0, 2'd2);
    reset = 1'b1;
    tick(1'b0, 2'd0);
    reset = 1'b0;
    tick(1'b0, 2'd0);
    gameOver = 1'b1;
    tick(1'b0, 2'd0);
    gameOver = 1'b0;
    keyStart = 1'b1;
    tick(1'b0, 2'd0);
    keyStart = 1'b0;
    tick(1'b1, 2'd1);
    idle(2, 2'd1);
    tick(1'b1, 2'd1);
    vectors++;
    if (screenState !== 2'd1) begin
      miscompares++;
      $display("FAIL stale_over got %0d want 1", screenState);
    end
  endtask

  task automatic test_back_to_back;
    rnd = 1'b1;
    reset = 1'b1;
    tick(1'b0, 2'd0);
    reset = 1'b0;
    tick(1'b0, 2'd0);
    keyStart = 1'b1;
    tick(1'b1, 2'd1);
    keyStart = 1'b0;
    vectors++;
    if (screenState !== 2'd1 || newGame !== 1'b1) begin
      miscompares++;
      $display("FAIL key_same_sof got %0d %b want 1 1",
               screenState, newGame);
    end
    idle(2, 2'd1);
    reset = 1'b1;
    tick(1'b0, 2'd0);
    reset = 1'b0;
    tick(1'b0, 2'd0);
    repeat (3) begin
      keyStart = 1'b1;
      tick(1'b0, 2'd0);
      keyStart = 1'b0;
      tick(1'b0, 2'd0);
    end
    tick(1'b1, 2'd1);
    idle(3, 2'd1);
    tick(1'b1, 2'd1);
    idle(2, 2'd1);
    vectors++;
    if (screenState !== 2'd1 || newGame !== 1'b0) begin
      miscompares++;
      $display("FAIL multi_edge got %0d %b want 1 0",
               screenState, newGame);
    end
    rnd = 1'b0;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rnd          = 1'b0;
    exp_st       = 2'd0;
    reset        = 1'b1;
    startOfFrame = 1'b0;
    keyStart     = 1'b0;
    gameOver     = 1'b0;
    pw           = 8'h1C;
    pg           = 8'hE0;
    po           = 8'h03;
    test_reset();
    test_key_through_reset();
    test_gameover_key();
    test_hold();
    test_reset_mid_game();
    test_same_cycle();
    test_back_to_back();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
